// File: rtl/pwm_pkg.sv
// -----------------------------------------------------------------------------
// pwm_pkg
// Shared types for the switch-driven PWM generator. Both the duty front-end
// (pwm_duty_ctrl) and the downstream PWM comparator import these so the duty
// code width is defined in exactly one place.
//
// Contents:
//   SW_W         width of the switch bank and of the duty code
//   duty_t       duty code type carried from the switches to the PWM stage
//   upd_state_t  states of the period-aligned duty update FSM
//   DUTY_ZERO    all-zero duty code, used as the reset value everywhere
// -----------------------------------------------------------------------------
package pwm_pkg;

  localparam int SW_W = 4;

  typedef logic [SW_W-1:0] duty_t;

  // IDLE: duty matches the debounced switches.
  // PEND: a new debounced value is waiting for the next period boundary.
  typedef enum logic {
    IDLE = 1'b0,
    PEND = 1'b1
  } upd_state_t;

  localparam duty_t DUTY_ZERO = {SW_W{1'b0}};

endpackage : pwm_pkg

// File: rtl/sw_debounce.sv
// -----------------------------------------------------------------------------
// sw_debounce
// Synchronises the raw switch bank into the clk domain and debounces it as a
// single 4-bit vector. A value is accepted into deb only after the
// synchronised bank has held it for DB_CYCLES consecutive counted cycles;
// any shorter excursion is discarded.
//
// Parameters:
//   DB_CYCLES  stable cycles needed before a value is accepted (2..2^DB_BITS)
//   DB_BITS    width of the stability counter
//
// Ports:
//   clk     in   sole clock, rising edge
//   rst     in   synchronous active-high reset
//   sw_raw  in   asynchronous switch bank
//   deb     out  registered debounced switch vector
// -----------------------------------------------------------------------------
module sw_debounce
  import pwm_pkg::*;
#(
  parameter int DB_CYCLES = 16,
  parameter int DB_BITS   = 5
) (
  input  logic            clk,
  input  logic            rst,
  input  logic [SW_W-1:0] sw_raw,
  output logic [SW_W-1:0] deb
);

  // Counter value at which the candidate has been stable long enough.
  localparam logic [DB_BITS-1:0] CNT_LAST = DB_BITS'(DB_CYCLES - 32'sd1);
  localparam logic [DB_BITS-1:0] CNT_ONE  = DB_BITS'(32'd1);
  localparam logic [DB_BITS-1:0] CNT_ZERO = {DB_BITS{1'b0}};

  duty_t               s1_r;
  duty_t               s2_r;
  duty_t               cand_r;
  logic [DB_BITS-1:0]  cnt_r;
  duty_t               deb_r;

  // Two-flop synchroniser; nothing else in the design looks at sw_raw.
  always_ff @(posedge clk) begin
    if (rst) begin
      s1_r <= DUTY_ZERO;
      s2_r <= DUTY_ZERO;
    end else begin
      s1_r <= sw_raw;
      s2_r <= s1_r;
    end
  end

  // Stability tracker: restart on any change of the synchronised vector,
  // count while it holds, and accept the candidate once the count saturates.
  always_ff @(posedge clk) begin
    if (rst) begin
      cand_r <= DUTY_ZERO;
      cnt_r  <= CNT_ZERO;
      deb_r  <= DUTY_ZERO;
    end else if (s2_r != cand_r) begin
      cand_r <= s2_r;
      cnt_r  <= CNT_ZERO;
    end else if (cnt_r != CNT_LAST) begin
      cnt_r  <= cnt_r + CNT_ONE;
    end else begin
      // Counter stays parked at CNT_LAST, so deb keeps tracking cand.
      deb_r  <= cand_r;
    end
  end

  assign deb = deb_r;

endmodule : sw_debounce

// File: rtl/pwm_duty_ctrl.sv
// -----------------------------------------------------------------------------
// pwm_duty_ctrl
// Front-end of the switch-driven PWM generator. The switch bank is debounced
// by sw_debounce; the debounced code is then held back in a shadow register
// and only transferred to duty at a PWM period boundary, so the comparator
// downstream never sees the duty change in the middle of a period.
//
// Parameters:
//   DB_CYCLES  stable cycles needed before a switch value is accepted
//   DB_BITS    debounce counter width (2^DB_BITS >= DB_CYCLES)
//
// Ports:
//   clk         in   sole clock, rising edge
//   rst         in   synchronous active-high reset
//   sw_raw      in   asynchronous 4-bit switch bank
//   period_end  in   pulse from the PWM counter on the cycle it wraps to 0
//   duty        out  registered duty code for the PWM stage
//   duty_upd    out  one-cycle pulse: duty changed on this edge
//   pending     out  a debounced value differs from duty and awaits period_end
// -----------------------------------------------------------------------------
module pwm_duty_ctrl
  import pwm_pkg::*;
#(
  parameter int DB_CYCLES = 16,
  parameter int DB_BITS   = 5
) (
  input  logic            clk,
  input  logic            rst,
  input  logic [SW_W-1:0] sw_raw,
  input  logic            period_end,
  output logic [SW_W-1:0] duty,
  output logic            duty_upd,
  output logic            pending
);

  duty_t       deb_s;
  upd_state_t  state_r;
  upd_state_t  state_s;
  duty_t       duty_r;
  duty_t       duty_s;
  logic        upd_r;
  logic        upd_s;
  logic        pend_r;

  sw_debounce #(
    .DB_CYCLES (DB_CYCLES),
    .DB_BITS   (DB_BITS)
  ) u_deb (
    .clk    (clk),
    .rst    (rst),
    .sw_raw (sw_raw),
    .deb    (deb_s)
  );

  // Update FSM next-state logic. The load at period_end uses the pre-edge
  // debounced value; if deb moves on that same edge, the mismatch is seen
  // again from IDLE and PEND is re-entered one edge later.
  always_comb begin
    state_s = state_r;
    duty_s  = duty_r;
    upd_s   = 1'b0;
    case (state_r)
      IDLE: begin
        if (deb_s != duty_r) begin
          state_s = PEND;
        end else begin
          state_s = IDLE;
        end
      end
      PEND: begin
        if (deb_s == duty_r) begin
          // Switches went back to the current duty: nothing left to load,
          // and loading would pulse duty_upd without a real change.
          state_s = IDLE;
        end else if (period_end) begin
          state_s = IDLE;
          duty_s  = deb_s;
          upd_s   = 1'b1;
        end else begin
          state_s = PEND;
        end
      end
      default: begin
        state_s = IDLE;
      end
    endcase
  end

  // State, shadow duty register and registered status outputs.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_r <= IDLE;
      duty_r  <= DUTY_ZERO;
      upd_r   <= 1'b0;
      pend_r  <= 1'b0;
    end else begin
      state_r <= state_s;
      duty_r  <= duty_s;
      upd_r   <= upd_s;
      pend_r  <= (state_s == PEND);
    end
  end

  assign duty     = duty_r;
  assign duty_upd = upd_r;
  assign pending  = pend_r;

endmodule : pwm_duty_ctrl

// File: tb/tb_pwm_duty_ctrl.sv
// -----------------------------------------------------------------------------
// tb_pwm_duty_ctrl
// Self-checking bench for pwm_duty_ctrl with DB_CYCLES=4. Directed scenarios
// compare against values worked out from the edge-numbered timing; a random
// phase compares every cycle against a run-length reference model.
// -----------------------------------------------------------------------------
module tb_pwm_duty_ctrl;

  localparam int DB = 4;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic [3:0] sw_raw = 4'h0;
  logic       period_end = 1'b0;
  logic [3:0] duty;
  logic       duty_upd;
  logic       pending;

  int n_checks = 0;
  int n_fail   = 0;
  int cyc      = 0;

  pwm_duty_ctrl #(
    .DB_CYCLES (DB),
    .DB_BITS   (3)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .sw_raw     (sw_raw),
    .period_end (period_end),
    .duty       (duty),
    .duty_upd   (duty_upd),
    .pending    (pending)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  // duty only moves (outside reset) on an edge where period_end was high.
  assert property (@(posedge clk) disable iff (cyc < 4)
    (!$past(rst) && (duty != $past(duty))) |-> $past(period_end))
    else $error("FAIL assert_duty_needs_period_end: duty=%h past=%h", duty, $past(duty));

  // duty_upd is only raised when duty really changed.
  assert property (@(posedge clk) disable iff (cyc < 4)
    duty_upd |-> (duty != $past(duty)))
    else $error("FAIL assert_upd_implies_change: duty=%h", duty);

  // Reference model: deb follows a value once the synchronised bank has shown
  // it for DB+1 consecutive samples; duty takes deb at a period_end that finds
  // a pending difference; pending means "deb differed from duty last edge and
  // was not just loaded".
  logic [3:0] m_s1, m_s2, m_run_val, m_deb, m_duty;
  int         m_run_len;
  logic       m_pend, m_upd;

  always @(posedge clk) begin
    if (rst) begin
      m_s1      <= 4'h0;
      m_s2      <= 4'h0;
      m_run_val <= 4'h0;
      m_run_len <= 1;
      m_deb     <= 4'h0;
      m_duty    <= 4'h0;
      m_pend    <= 1'b0;
      m_upd     <= 1'b0;
    end else begin
      m_s1 <= sw_raw;
      m_s2 <= m_s1;
      if (m_s2 != m_run_val) begin
        m_run_val <= m_s2;
        m_run_len <= 1;
      end else begin
        m_run_len <= m_run_len + 1;
        if (m_run_len + 1 > DB) m_deb <= m_run_val;
      end
      m_pend <= (m_deb != m_duty) && !(m_pend && period_end);
      m_upd  <= m_pend && period_end && (m_deb != m_duty);
      if (m_pend && period_end && (m_deb != m_duty)) m_duty <= m_deb;
    end
  end

  task automatic test_reset();
    rst = 1'b1;
    sw_raw = 4'hF;
    period_end = 1'b0;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      n_checks++;
      if (duty !== 4'h0 || pending !== 1'b0 || duty_upd !== 1'b0) begin
        n_fail++;
        $display("FAIL reset_hold[%0d]: duty=%h pending=%b upd=%b, want 0/0/0", i, duty, pending, duty_upd);
      end
    end
    rst = 1'b0;
    @(negedge clk);
    n_checks++;
    if (duty !== 4'h0 || pending !== 1'b0 || duty_upd !== 1'b0) begin
      n_fail++;
      $display("FAIL reset_first_cycle: duty=%h pending=%b upd=%b, want 0/0/0", duty, pending, duty_upd);
    end
    // A single sampled F after reset is a glitch and must not get through.
    sw_raw = 4'h0;
    for (int i = 0; i < 12; i++) begin
      @(negedge clk);
      n_checks++;
      if (duty !== 4'h0 || pending !== 1'b0 || dut.deb_s !== 4'h0) begin
        n_fail++;
        $display("FAIL reset_settle[%0d]: duty=%h pending=%b deb=%h, want 0/0/0", i, duty, pending, dut.deb_s);
      end
    end
  endtask

  task automatic test_bounce();
    for (int i = 0; i < 20; i++) begin
      sw_raw = ((i / 2) % 2 == 0) ? 4'h6 : 4'h0;
      period_end = (i % 7 == 3);
      @(negedge clk);
      n_checks++;
      if (dut.deb_s !== 4'h0 || pending !== 1'b0 || duty_upd !== 1'b0 || duty !== 4'h0) begin
        n_fail++;
        $display("FAIL bounce[%0d]: deb=%h pending=%b upd=%b duty=%h, want 0/0/0/0", i, dut.deb_s, pending, duty_upd, duty);
      end
    end
    sw_raw = 4'h0;
    period_end = 1'b0;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      n_checks++;
      if (dut.deb_s !== 4'h0 || pending !== 1'b0 || duty_upd !== 1'b0) begin
        n_fail++;
        $display("FAIL bounce_settle[%0d]: deb=%h pending=%b upd=%b, want 0/0/0", i, dut.deb_s, pending, duty_upd);
      end
    end
  endtask

  task automatic test_clean_change();
    sw_raw = 4'hA;
    for (int e = 1; e <= 14; e++) begin
      period_end = (e == 12);
      @(negedge clk);
      n_checks++;
      if (dut.deb_s !== ((e >= 7) ? 4'hA : 4'h0) ||
          pending !== ((e >= 8 && e < 12) ? 1'b1 : 1'b0) ||
          duty !== ((e >= 12) ? 4'hA : 4'h0) ||
          duty_upd !== ((e == 12) ? 1'b1 : 1'b0)) begin
        n_fail++;
        $display("FAIL clean_change edge %0d: deb=%h pending=%b duty=%h upd=%b", e, dut.deb_s, pending, duty, duty_upd);
      end
    end
    period_end = 1'b0;
  endtask

  task automatic test_retarget();
    sw_raw = 4'h3;
    for (int e = 1; e <= 8; e++) begin
      @(negedge clk);
      n_checks++;
      if (pending !== ((e >= 8) ? 1'b1 : 1'b0) || duty_upd !== 1'b0 || duty !== 4'hA) begin
        n_fail++;
        $display("FAIL retarget_first edge %0d: pending=%b upd=%b duty=%h, want pend=%0d/0/a", e, pending, duty_upd, duty, (e >= 8));
      end
    end
    sw_raw = 4'hC;
    for (int e = 1; e <= 10; e++) begin
      @(negedge clk);
      n_checks++;
      if (pending !== 1'b1 || duty_upd !== 1'b0 || duty !== 4'hA) begin
        n_fail++;
        $display("FAIL retarget_hold edge %0d: pending=%b upd=%b duty=%h, want 1/0/a", e, pending, duty_upd, duty);
      end
    end
    period_end = 1'b1;
    @(negedge clk);
    period_end = 1'b0;
    n_checks++;
    if (duty !== 4'hC || duty_upd !== 1'b1 || pending !== 1'b0) begin
      n_fail++;
      $display("FAIL retarget_load: duty=%h upd=%b pending=%b, want c/1/0", duty, duty_upd, pending);
    end
    @(negedge clk);
    n_checks++;
    if (duty !== 4'hC || duty_upd !== 1'b0 || pending !== 1'b0) begin
      n_fail++;
      $display("FAIL retarget_after: duty=%h upd=%b pending=%b, want c/0/0", duty, duty_upd, pending);
    end
  endtask

  task automatic test_revert();
    sw_raw = 4'h2;
    repeat (8) @(negedge clk);
    period_end = 1'b1;
    @(negedge clk);
    period_end = 1'b0;
    @(negedge clk);
    n_checks++;
    if (duty !== 4'h2 || pending !== 1'b0) begin
      n_fail++;
      $display("FAIL revert_setup: duty=%h pending=%b, want 2/0", duty, pending);
    end
    sw_raw = 4'h5;
    repeat (8) @(negedge clk);
    n_checks++;
    if (pending !== 1'b1 || duty !== 4'h2) begin
      n_fail++;
      $display("FAIL revert_pending: pending=%b duty=%h, want 1/2", pending, duty);
    end
    sw_raw = 4'h2;
    for (int e = 1; e <= 8; e++) begin
      @(negedge clk);
      n_checks++;
      if (pending !== ((e < 8) ? 1'b1 : 1'b0) || duty_upd !== 1'b0 || duty !== 4'h2) begin
        n_fail++;
        $display("FAIL revert_back edge %0d: pending=%b upd=%b duty=%h", e, pending, duty_upd, duty);
      end
    end
    period_end = 1'b1;
    @(negedge clk);
    period_end = 1'b0;
    n_checks++;
    if (duty_upd !== 1'b0 || duty !== 4'h2 || pending !== 1'b0) begin
      n_fail++;
      $display("FAIL revert_period_end: upd=%b duty=%h pending=%b, want 0/2/0", duty_upd, duty, pending);
    end
  endtask

  task automatic test_simultaneous_and_reset();
    sw_raw = 4'h7;
    repeat (8) @(negedge clk);
    sw_raw = 4'h9;
    for (int e = 1; e <= 7; e++) begin
      period_end = (e == 7);
      @(negedge clk);
      if (e < 7) begin
        n_checks++;
        if (pending !== 1'b1 || duty !== 4'h2 || duty_upd !== 1'b0) begin
          n_fail++;
          $display("FAIL simul_wait edge %0d: pending=%b duty=%h upd=%b, want 1/2/0", e, pending, duty, duty_upd);
        end
      end
    end
    period_end = 1'b0;
    n_checks++;
    if (duty !== 4'h7 || duty_upd !== 1'b1 || pending !== 1'b0 || dut.deb_s !== 4'h9) begin
      n_fail++;
      $display("FAIL simul_load: duty=%h upd=%b pending=%b deb=%h, want 7/1/0/9", duty, duty_upd, pending, dut.deb_s);
    end
    @(negedge clk);
    n_checks++;
    if (pending !== 1'b1 || duty_upd !== 1'b0 || duty !== 4'h7) begin
      n_fail++;
      $display("FAIL simul_reenter: pending=%b upd=%b duty=%h, want 1/0/7", pending, duty_upd, duty);
    end
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    n_checks++;
    if (duty !== 4'h0 || pending !== 1'b0 || duty_upd !== 1'b0) begin
      n_fail++;
      $display("FAIL reset_in_pend: duty=%h pending=%b upd=%b, want 0/0/0", duty, pending, duty_upd);
    end
    @(negedge clk);
    n_checks++;
    if (duty !== 4'h0 || pending !== 1'b0 || duty_upd !== 1'b0) begin
      n_fail++;
      $display("FAIL reset_in_pend_after: duty=%h pending=%b upd=%b, want 0/0/0", duty, pending, duty_upd);
    end
  endtask

  task automatic test_random();
    int hold = 0;
    for (int i = 0; i < 600; i++) begin
      if (hold == 0) begin
        sw_raw = 4'($urandom_range(0, 15));
        hold = $urandom_range(1, 9);
      end
      hold--;
      period_end = ($urandom_range(0, 3) == 0);
      rst = ($urandom_range(0, 249) == 0);
      @(negedge clk);
      n_checks++;
      if (duty !== m_duty || duty_upd !== m_upd || pending !== m_pend) begin
        n_fail++;
        $display("FAIL random[%0d]: duty=%h upd=%b pending=%b, model %h/%b/%b", i, duty, duty_upd, pending, m_duty, m_upd, m_pend);
      end
    end
    rst = 1'b0;
    period_end = 1'b0;
  endtask

  initial begin
    test_reset();
    test_bounce();
    test_clean_change();
    test_retarget();
    test_revert();
    test_simultaneous_and_reset();
    test_random();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule : tb_pwm_duty_ctrl
